dac_spi_tx: RTL and testbench
=============================

DAC_SPI_TX -- requirements
Module: dac_spi_tx

Interface
REQ-001: The block SHALL provide parameter CLK_DIV, default 2; clk cycles per half SCLK period; legal range 1..255.
REQ-002: The block SHALL provide port clk, input, 1 bit; system clock; the only clock, all logic on its rising edge.
REQ-003: The block SHALL provide port rst, input, 1 bit; asynchronous, active-high reset.
REQ-004: The block SHALL provide port start, input, 1 bit; request to send one sample, sampled only in IDLE.
REQ-005: The block SHALL provide port data, input, 12 bits; unsigned DAC code, captured on start acceptance.
REQ-006: The block SHALL provide port dac_sync_n, output, 1 bit; DAC frame select, active-low.
REQ-007: The block SHALL provide port dac_sclk, output, 1 bit; DAC serial clock, idles high.
REQ-008: The block SHALL provide port dac_sdata, output, 1 bit; serial data, MSB first.
REQ-009: The block SHALL provide port busy, output, 1 bit; high while a frame is in progress.
REQ-010: The block SHALL provide port done_tick, output, 1 bit; one-cycle pulse at frame completion.

Function
REQ-011: The block SHALL implement FSM states IDLE, SHIFT and DONE, plus a half-period counter and a 4-bit bit counter.
REQ-012: In IDLE with start=1, the block SHALL latch the frame {2'b00, 2'b00, data[11:0]} (16 bits) and enter SHIFT on the next edge; in IDLE with start=0 it SHALL remain in IDLE.
REQ-013: In SHIFT, dac_sync_n SHALL be 0 for exactly 32*CLK_DIV consecutive cycles, starting in the cycle after acceptance.
REQ-014: Each bit window SHALL be 2*CLK_DIV cycles: dac_sclk high for CLK_DIV cycles, then low for CLK_DIV cycles.
REQ-015: The DAC samples on each dac_sclk falling edge, so there SHALL be exactly 16 falling edges per frame.
REQ-016: dac_sdata SHALL hold frame bit 15-k for the whole of window k (k=0..15) and change only at window boundaries (dac_sclk rising).
REQ-017: After window 15, the block SHALL enter DONE for CLK_DIV cycles with dac_sync_n=1, dac_sclk=1 and dac_sdata=0; done_tick SHALL be 1 in the last DONE cycle only; the block SHALL then return to IDLE.
REQ-018: busy SHALL be 1 from the first SHIFT cycle through the last DONE cycle inclusive, and 0 in IDLE.
REQ-019: start while busy=1, including the done_tick cycle, SHALL be ignored and SHALL not be queued.
REQ-020: A change on data after acceptance SHALL not affect the frame in flight.
REQ-021: Minimum start-to-start period SHALL be 33*CLK_DIV+1 cycles.
REQ-022: In IDLE the outputs SHALL be dac_sync_n=1, dac_sclk=1, dac_sdata=0, busy=0 and done_tick=0.

Reset
REQ-023: rst=1 SHALL immediately force IDLE, clear both counters and the frame register, and set dac_sync_n=1, dac_sclk=1, dac_sdata=0, busy=0, done_tick=0.
REQ-024: Reset mid-frame SHALL abort the frame with no done_tick; after release, the next start SHALL send a complete fresh frame.

Configuration
REQ-025: With macro DAC_PD_MODE_EN defined, the block SHALL add input port pd_mode (2 bits), captured with data, and the frame SHALL be {2'b00, pd_mode, data}.
REQ-026: Without DAC_PD_MODE_EN, port pd_mode SHALL be absent and frame bits 13:12 SHALL be 00 (normal operation).

Verification
REQ-027: Scenario, CLK_DIV=2, data=0xABC, single start -> dac_sync_n low 64 cycles; 16 falling edges sample 0000_1010_1011_1100; done_tick 1 cycle; busy 0 thereafter.
REQ-028: Scenario, start held high continuously, data=0xFFF then 0x000 changed mid-frame -> first frame 0x0FFF intact; second frame 0x0000 accepted in the first IDLE cycle after DONE; no start queued during busy.
REQ-029: Scenario, rst pulsed after the 7th falling edge -> outputs at idle values within the same cycle; no done_tick; next start with data=0x123 sends full frame 0x0123.
REQ-030: Scenario, CLK_DIV=1, data=0x800 -> frame length 32 cycles; dac_sclk period 2 cycles; the single 1 is sampled at falling edge 5.
REQ-031: Scenario, DAC_PD_MODE_EN defined, pd_mode=2'b11, data=0x555 -> sampled frame 0011_0101_0101_0101; without the macro the same stimulus yields 0000_0101_0101_0101.

Source files
------------

// File: rtl/dac_spi_tx.sv
// dac_spi_tx: serialises one 12-bit DAC code as a 16-bit SPI frame (MSB first, sync_n framed).
// Latency: frame starts the cycle after start is accepted; 32*CLK_DIV shift cycles + CLK_DIV done cycles.
// Backpressure: start is honoured only in IDLE; requests while busy (incl. done_tick cycle) are dropped.
//
// Ports:
//   clk, rst          - system clock (rising edge), asynchronous active-high reset
//   start, data[11:0] - send request and DAC code, both sampled only while idle
//   pd_mode[1:0]      - power-down mode bits, present only when DAC_PD_MODE_EN is defined
//   dac_sync_n        - frame select, low for the 16 bit windows
//   dac_sclk          - serial clock, idles high, DAC samples on its falling edge
//   dac_sdata         - serial data, changes only when dac_sclk rises (window boundary)
//   busy, done_tick   - frame in progress / one-cycle pulse in the last DONE cycle
//
// Optional feature macro: DAC_PD_MODE_EN (adds pd_mode, placed in frame bits 13:12).
// Parameter CLK_DIV: clk cycles per half SCLK period, 1..255.

module dac_spi_tx #(
    parameter int CLK_DIV = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [11:0] data,
`ifdef DAC_PD_MODE_EN
    input  logic [1:0]  pd_mode,
`endif
    output logic        dac_sync_n,
    output logic        dac_sclk,
    output logic        dac_sdata,
    output logic        busy,
    output logic        done_tick
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    // Terminal count of the half-period counter.
    localparam logic [7:0] HALF_MAX = 8'(CLK_DIV - 1);

    // Bits 13:12 of the frame: the power-down selection, or 00 (normal operation).
    logic [1:0] pd_eff;
`ifdef DAC_PD_MODE_EN
    assign pd_eff = pd_mode;
`else
    assign pd_eff = 2'b00;
`endif

    logic [1:0]  state_q, state_d;
    logic [7:0]  hcnt_q, hcnt_d;     // cycles within the current half period
    logic        phase_q, phase_d;   // 0: SCLK-high half of a window, 1: SCLK-low half
    logic [3:0]  bit_q, bit_d;       // index k of the current bit window
    logic [15:0] frame_q, frame_d;   // shift register; bit 15 is the bit on the wire

    logic half_end;
    assign half_end = (hcnt_q == HALF_MAX);

    always_comb begin
        state_d = state_q;
        hcnt_d  = hcnt_q;
        phase_d = phase_q;
        bit_d   = bit_q;
        frame_d = frame_q;

        case (state_q)
            ST_IDLE: begin
                hcnt_d  = 8'd0;
                phase_d = 1'b0;
                bit_d   = 4'd0;
                if (start) begin
                    frame_d = {2'b00, pd_eff, data};
                    state_d = ST_SHIFT;
                end
            end

            ST_SHIFT: begin
                if (half_end) begin
                    hcnt_d = 8'd0;
                    if (!phase_q) begin
                        // SCLK falls here; data stays put so the DAC samples a stable bit.
                        phase_d = 1'b1;
                    end else begin
                        // Window boundary: SCLK rises and the next bit moves to the wire.
                        phase_d = 1'b0;
                        frame_d = {frame_q[14:0], 1'b0};
                        bit_d   = bit_q + 4'd1;
                        if (bit_q == 4'd15) begin
                            state_d = ST_DONE;
                        end
                    end
                end else begin
                    hcnt_d = hcnt_q + 8'd1;
                end
            end

            ST_DONE: begin
                if (half_end) begin
                    hcnt_d  = 8'd0;
                    state_d = ST_IDLE;
                end else begin
                    hcnt_d = hcnt_q + 8'd1;
                end
            end

            default: begin
                state_d = ST_IDLE;
                hcnt_d  = 8'd0;
                phase_d = 1'b0;
                bit_d   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            hcnt_q  <= 8'd0;
            phase_q <= 1'b0;
            bit_q   <= 4'd0;
            frame_q <= 16'd0;
        end else begin
            state_q <= state_d;
            hcnt_q  <= hcnt_d;
            phase_q <= phase_d;
            bit_q   <= bit_d;
            frame_q <= frame_d;
        end
    end

    // Outputs decode directly from reset flops, so an asserted rst reaches the
    // pins in the same cycle without waiting for a clock edge.
    assign busy       = (state_q != ST_IDLE);
    assign dac_sync_n = (state_q != ST_SHIFT);
    assign dac_sclk   = !((state_q == ST_SHIFT) && phase_q);
    assign dac_sdata  = (state_q == ST_SHIFT) && frame_q[15];
    assign done_tick  = (state_q == ST_DONE) && half_end;

endmodule

// File: tb/tb_dac_spi_tx.sv
// tb_dac_spi_tx: two DUT instances (CLK_DIV=2 and CLK_DIV=1) driven with directed and random requests.
// A reference model predicts acceptance, frame contents and per-cycle pin values from frame arithmetic.
// Expected frames are queued at acceptance; a negedge monitor reassembles frames from SCLK falls and compares.

module tb_dac_spi_tx;

    localparam int D0 = 2;
    localparam int D1 = 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        st [2];
    logic [11:0] dt [2];
    logic [1:0]  pd [2];
    logic        sync_n [2];
    logic        sclk [2];
    logic        sdata [2];
    logic        busy [2];
    logic        done [2];

    dac_spi_tx #(.CLK_DIV(D0)) u_dut0 (
        .clk        (clk),
        .rst        (rst),
        .start      (st[0]),
        .data       (dt[0]),
`ifdef DAC_PD_MODE_EN
        .pd_mode    (pd[0]),
`endif
        .dac_sync_n (sync_n[0]),
        .dac_sclk   (sclk[0]),
        .dac_sdata  (sdata[0]),
        .busy       (busy[0]),
        .done_tick  (done[0])
    );

    dac_spi_tx #(.CLK_DIV(D1)) u_dut1 (
        .clk        (clk),
        .rst        (rst),
        .start      (st[1]),
        .data       (dt[1]),
`ifdef DAC_PD_MODE_EN
        .pd_mode    (pd[1]),
`endif
        .dac_sync_n (sync_n[1]),
        .dac_sclk   (sclk[1]),
        .dac_sdata  (sdata[1]),
        .busy       (busy[1]),
        .done_tick  (done[1])
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;   // number of rising edges seen so far

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model state: one frame in flight per instance.
    bit          acc_v [2];
    int          acc_e [2];   // edge index at which start was accepted
    logic [15:0] acc_f [2];
    int          free_e [2];  // earliest edge index at which a new start is honoured
    logic [15:0] q0 [$];
    logic [15:0] q1 [$];

    function automatic int div_of(input int i);
        return (i == 0) ? D0 : D1;
    endfunction

    function automatic logic [15:0] make_frame(input logic [1:0] p, input logic [11:0] d);
`ifdef DAC_PD_MODE_EN
        return {2'b00, p, d};
`else
        return {2'b00, 2'b00, d};
`endif
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    // Evaluates acceptance for the coming edge, then advances one clock.
    task automatic step();
        int e;
        e = cyc + 1;
        for (int i = 0; i < 2; i++) begin
            if (st[i] && !rst && e >= free_e[i]) begin
                acc_v[i]  = 1'b1;
                acc_e[i]  = e;
                acc_f[i]  = make_frame(pd[i], dt[i]);
                free_e[i] = e + 33 * div_of(i) + 1;
                if (i == 0) q0.push_back(acc_f[i]);
                else        q1.push_back(acc_f[i]);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            acc_v[i]  = 1'b0;
            free_e[i] = 0;
        end
        q0.delete();
        q1.delete();
    endtask

    task automatic chk_idle_pins(input string name);
        for (int i = 0; i < 2; i++)
            chk(name, {sync_n[i], sclk[i], sdata[i], busy[i], done[i]}, 5'b11000);
    endtask

    // Monitor: per-cycle pin prediction plus frame reassembly from SCLK falls.
    logic [15:0] mb [2];
    int          nb [2];
    int          lc [2];
    logic        ps [2];
    logic        py [2];

    initial begin
        for (int i = 0; i < 2; i++) begin
            mb[i] = '0; nb[i] = 0; lc[i] = 0; ps[i] = 1'b1; py[i] = 1'b1;
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                chk("reset_pins", {sync_n[i], sclk[i], sdata[i], busy[i], done[i]}, 5'b11000);
                mb[i] = '0; nb[i] = 0; lc[i] = 0; ps[i] = 1'b1; py[i] = 1'b1;
            end else begin
                int d, off;
                bit in_frame, shifting;
                logic [4:0] exp_pins;
                logic [15:0] want;
                d = div_of(i);
                off = cyc - acc_e[i];
                in_frame = acc_v[i] && off >= 0 && off <= 33 * d - 1;
                shifting = in_frame && off < 32 * d;
                exp_pins[4] = !shifting;
                exp_pins[3] = shifting ? ((off % (2 * d)) < d) : 1'b1;
                exp_pins[2] = shifting ? acc_f[i][15 - off / (2 * d)] : 1'b0;
                exp_pins[1] = in_frame;
                exp_pins[0] = in_frame && off == 33 * d - 1;
                chk((i == 0) ? "pins_div2" : "pins_div1",
                    {sync_n[i], sclk[i], sdata[i], busy[i], done[i]}, exp_pins);

                if (!sync_n[i]) lc[i]++;
                if (ps[i] && !sclk[i]) begin
                    mb[i] = {mb[i][14:0], sdata[i]};
                    nb[i]++;
                end
                if (sync_n[i] && !py[i]) begin
                    if (i == 0 && q0.size() == 0 || i == 1 && q1.size() == 0) begin
                        failures++;
                        checks++;
                        $display("FAIL unexpected_frame inst %0d: got 0x%0h expected none", i, mb[i]);
                    end else begin
                        want = (i == 0) ? q0.pop_front() : q1.pop_front();
                        chk("frame_bits", mb[i], want);
                        chk("fall_count", nb[i], 16);
                        chk("sync_low_len", lc[i], 32 * d);
                    end
                    mb[i] = '0; nb[i] = 0; lc[i] = 0;
                end
                ps[i] = sclk[i];
                py[i] = sync_n[i];
            end
        end
    end

    initial begin
        for (int i = 0; i < 2; i++) begin
            st[i] = 1'b0; dt[i] = '0; pd[i] = '0;
        end
        model_reset();
        #1;
        chk_idle_pins("reset_initial");
        steps(3);
        rst = 1'b0;
        steps(2);

        // Single frame, 0xABC.
        pd[0] = 2'b00; dt[0] = 12'hABC; st[0] = 1'b1;
        step();
        st[0] = 1'b0;
        steps(33 * D0 + 5);

        // Start held high; data changes mid-frame; done_tick-cycle start must not queue.
        dt[0] = 12'hFFF; st[0] = 1'b1;
        steps(10);
        dt[0] = 12'h000;
        steps(2 * (33 * D0 + 1) - 10);
        st[0] = 1'b0;
        steps(33 * D0 + 5);

        // Reset after the 7th falling edge.
        dt[0] = 12'h3C5; st[0] = 1'b1;
        step();
        st[0] = 1'b0;
        steps(13 * D0 + 1);
        rst = 1'b1;
        model_reset();
        #1;
        chk_idle_pins("reset_midframe");
        steps(2);
        rst = 1'b0;
        steps(2);
        dt[0] = 12'h123; st[0] = 1'b1;
        step();
        st[0] = 1'b0;
        steps(33 * D0 + 5);

        // Power-down bits, 0x555.
        pd[0] = 2'b11; dt[0] = 12'h555; st[0] = 1'b1;
        step();
        st[0] = 1'b0;
        steps(33 * D0 + 5);

        // CLK_DIV=1, single set bit.
        pd[1] = 2'b00; dt[1] = 12'h800; st[1] = 1'b1;
        step();
        st[1] = 1'b0;
        steps(33 * D1 + 5);

        // Random traffic on both instances.
        for (int n = 0; n < 600; n++) begin
            for (int i = 0; i < 2; i++) begin
                st[i] = ($urandom_range(0, 3) == 0);
                dt[i] = 12'($urandom);
                pd[i] = 2'($urandom);
            end
            step();
        end
        st[0] = 1'b0;
        st[1] = 1'b0;
        steps(33 * D0 + 10);

        chk("pending_frames_div2", q0.size(), 0);
        chk("pending_frames_div1", q1.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
